stb_occ_chk: RTL

STB_OCC_CHK -- requirements
Module: stb_occ_chk

---
 rtl/stb_occ_pkg.sv | 27 ++
 rtl/stb_occ_chk_thr.sv | 68 ++++++
 rtl/stb_occ_chk.sv | 107 ++++++++++
 3 files changed

// File: rtl/stb_occ_pkg.sv
// Shared definitions for the store-buffer occupancy monitor:
// error-code encodings, error-total width and a code helper.
package stb_occ_pkg;

    localparam int TOTAL_W = 8;
    localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_OVFL = 2'b01,
        ERR_STEP = 2'b10,
        ERR_BOTH = 2'b11
    } err_code_e;

    // Combine the two per-thread conditions into a reported error code.
    function automatic err_code_e err_encode(input logic ovfl, input logic step);
        err_code_e code;
        unique case ({step, ovfl})
            2'b01:   code = ERR_OVFL;
            2'b10:   code = ERR_STEP;
            2'b11:   code = ERR_BOTH;
            default: code = ERR_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/stb_occ_chk_thr.sv
// Per-thread occupancy checker: flush holdoff, previous-count register,
// overflow and step compares, and high-water mark.
module stb_occ_thr #(
    parameter int CNT_W     = 4,
    parameter int STB_DEPTH = 8,
    parameter int HOLDOFF   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             flush_i,
    output logic             ovfl_o,
    output logic             step_o,
    output logic [CNT_W-1:0] hwm_o
);

    localparam int HO_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [HO_W-1:0]  HOLD_LD = HO_W'(HOLDOFF);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STB_DEPTH);

    logic [HO_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0] prev_q;
    logic [CNT_W-1:0] hwm_q, hwm_d;
    logic [CNT_W-1:0] delta;
    logic             armed_q;
    logic             armed;

    // Arming, compares, holdoff countdown and high-water mark next state.
    always_comb begin
        armed  = (hold_q == '0) && !flush_i;
        delta  = (cnt_i >= prev_q) ? (cnt_i - prev_q) : (prev_q - cnt_i);
        ovfl_o = armed && (cnt_i > DEPTH_C);
        // prev only reflects real traffic once the thread was armed last edge too
        step_o = armed && armed_q && (delta > CNT_W'(1));

        hold_d = hold_q;
        if (flush_i) begin
            hold_d = HOLD_LD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HO_W'(1);
        end

        hwm_d = hwm_q;
        if (flush_i) begin
            hwm_d = '0;
        end else if (armed && (cnt_i > hwm_q)) begin
            hwm_d = cnt_i;
        end
    end

    // Per-thread state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q  <= HOLD_LD;
            prev_q  <= '0;
            armed_q <= 1'b0;
            hwm_q   <= '0;
        end else begin
            hold_q  <= hold_d;
            prev_q  <= cnt_i;
            armed_q <= armed;
            hwm_q   <= hwm_d;
        end
    end

    assign hwm_o = hwm_q;

endmodule

// File: rtl/stb_occ_chk.sv
// Store-buffer occupancy checker top: one checker per thread, lowest-index
// priority select, registered error report, saturating total and fail flag.
module stb_occ_chk
    import stb_occ_pkg::*;
#(
    parameter int NUM_THR   = 4,
    parameter int STB_DEPTH = 8,
    parameter int CNT_W     = 4,
    parameter int HOLDOFF   = 1
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [9:0]                                       coreid,
    input  logic                                             chk_en,
    input  logic [NUM_THR*CNT_W-1:0]                         stbcnt,
    input  logic [NUM_THR-1:0]                               stb_flush,
    output logic                                             err_vld,
    output logic [1:0]                                       err_code,
    output logic [((NUM_THR > 1) ? $clog2(NUM_THR) : 1)-1:0] err_tid,
    output logic [TOTAL_W-1:0]                               err_total,
    output logic [NUM_THR-1:0]                               ovfl_sticky,
    output logic [NUM_THR*CNT_W-1:0]                         hwm,
    output logic                                             fail
);

    localparam int TID_W = (NUM_THR > 1) ? $clog2(NUM_THR) : 1;

    logic [NUM_THR-1:0] thr_ovfl;
    logic [NUM_THR-1:0] thr_step;

    logic               any_err;
    logic [TID_W-1:0]   sel_tid;
    err_code_e          sel_code;

    logic               err_vld_q;
    err_code_e          err_code_q;
    logic [TID_W-1:0]   err_tid_q;
    logic [TOTAL_W-1:0] err_total_q, err_total_d;
    logic [NUM_THR-1:0] ovfl_sticky_q;
    logic               fail_q;

    // coreid is only echoed by the simulation-side error report.
    logic unused_coreid;
    assign unused_coreid = ^coreid;

    for (genvar t = 0; t < NUM_THR; t++) begin : g_thr
        stb_occ_thr #(
            .CNT_W     (CNT_W),
            .STB_DEPTH (STB_DEPTH),
            .HOLDOFF   (HOLDOFF)
        ) u_thr (
            .clk_i   (clk),
            .rst_i   (rst),
            .cnt_i   (stbcnt[t*CNT_W +: CNT_W]),
            .flush_i (stb_flush[t]),
            .ovfl_o  (thr_ovfl[t]),
            .step_o  (thr_step[t]),
            .hwm_o   (hwm[t*CNT_W +: CNT_W])
        );
    end

    // Lowest-numbered erring thread wins; scan downward so it is assigned last.
    always_comb begin
        any_err  = 1'b0;
        sel_tid  = '0;
        sel_code = ERR_NONE;
        for (int t = NUM_THR - 1; t >= 0; t--) begin
            if (thr_ovfl[t] || thr_step[t]) begin
                any_err  = 1'b1;
                sel_tid  = TID_W'(t);
                sel_code = err_encode(thr_ovfl[t], thr_step[t]);
            end
        end
        // the total counts the cycle whose err_vld this same edge produces
        err_total_d = err_total_q;
        if (any_err && (err_total_q != TOTAL_MAX)) begin
            err_total_d = err_total_q + TOTAL_W'(1);
        end
    end

    // Registered error report, sticky flags and fail.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_vld_q     <= 1'b0;
            err_code_q    <= ERR_NONE;
            err_tid_q     <= '0;
            err_total_q   <= '0;
            ovfl_sticky_q <= '0;
            fail_q        <= 1'b0;
        end else begin
            err_vld_q     <= any_err;
            err_code_q    <= sel_code;
            err_tid_q     <= sel_tid;
            err_total_q   <= err_total_d;
            ovfl_sticky_q <= ovfl_sticky_q | thr_ovfl;
            fail_q        <= fail_q | (any_err & chk_en);
        end
    end

    assign err_vld     = err_vld_q;
    assign err_code    = err_code_q;
    assign err_tid     = err_tid_q;
    assign err_total   = err_total_q;
    assign ovfl_sticky = ovfl_sticky_q;
    assign fail        = fail_q;

endmodule
